// File: rtl/iob_timer_alarm_if.sv
// iob_timer_alarm_if: control/status bundle between the timer register file and the alarm stage
//  master: drives cnt_i, deadline_wr, deadline_i, period_i, periodic_i, arm, disarm, irq_ack
//  slave : drives irq, armed, deadline_o, miss_cnt
interface iob_timer_alarm_if #(
  parameter int CNT_W    = 64,
  parameter int PERIOD_W = 32,
  parameter int MISS_W   = 8
);
  logic [CNT_W-1:0]    cnt_i;
  logic                deadline_wr;
  logic [CNT_W-1:0]    deadline_i;
  logic [PERIOD_W-1:0] period_i;
  logic                periodic_i;
  logic                arm;
  logic                disarm;
  logic                irq_ack;
  logic                irq;
  logic                armed;
  logic [CNT_W-1:0]    deadline_o;
  logic [MISS_W-1:0]   miss_cnt;
  modport master (
    output cnt_i, deadline_wr, deadline_i, period_i, periodic_i, arm, disarm, irq_ack,
    input  irq, armed, deadline_o, miss_cnt
  );
  modport slave (
    input  cnt_i, deadline_wr, deadline_i, period_i, periodic_i, arm, disarm, irq_ack,
    output irq, armed, deadline_o, miss_cnt
  );
endinterface

// File: rtl/iob_timer_alarm.sv
// iob_timer_alarm: wrap-safe 64-bit deadline compare with one-shot/periodic level irq and miss counter
//  clk : system clock
//  rst : asynchronous active-low reset
//  bus : iob_timer_alarm_if slave (counter/deadline/control in, irq/armed/deadline/miss out)
module iob_timer_alarm #(
  parameter int CNT_W    = 64,
  parameter int PERIOD_W = 32,
  parameter int MISS_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  iob_timer_alarm_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;
  state_t              state_q, state_d;
  logic                irq_q, irq_d, armed_q, armed_d, periodic_q, periodic_d;
  logic [CNT_W-1:0]    deadline_q, deadline_d, diff;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                hit, fire, reload;
  // Signed-distance compare: deadline counts as reached when it lies within the past half range.
  assign diff   = bus.cnt_i - deadline_q;
  assign hit    = ~diff[CNT_W-1];
  // A deadline write, disarm or arm on this edge pre-empts a fire from the old settings.
  assign fire   = (state_q == ARMED) && hit && !bus.deadline_wr && !bus.disarm && !bus.arm;
  assign reload = periodic_q && (period_q != '0);
  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q && !bus.irq_ack;
    period_d   = period_q;
    periodic_d = periodic_q;
    miss_d     = miss_q;
    deadline_d = deadline_q;
    if (bus.disarm) begin
      state_d = IDLE;
      irq_d   = 1'b0;
    end else if (bus.arm) begin
      state_d    = ARMED;
      period_d   = bus.period_i;
      periodic_d = bus.periodic_i;
      if (state_q == IDLE) miss_d = '0;
    end else if (fire) begin
      irq_d   = 1'b1;
      state_d = reload ? ARMED : FIRED;
      // An ack landing with a fire absorbs that fire rather than counting it as missed.
      if (irq_q && !bus.irq_ack && miss_q != '1) miss_d = miss_q + MISS_W'(1);
      if (reload) deadline_d = deadline_q + CNT_W'(period_q);
    end
    if (bus.deadline_wr) deadline_d = bus.deadline_i;
    armed_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      armed_q    <= 1'b0;
      period_q   <= '0;
      periodic_q <= 1'b0;
      miss_q     <= '0;
      deadline_q <= '0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      armed_q    <= armed_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      miss_q     <= miss_d;
      deadline_q <= deadline_d;
    end
  end
  assign bus.irq        = irq_q;
  assign bus.armed      = armed_q;
  assign bus.deadline_o = deadline_q;
  assign bus.miss_cnt   = miss_q;
endmodule

// File: tb/tb_iob_timer_alarm.sv
// tb_iob_timer_alarm: directed vectors with hand-computed expectations for iob_timer_alarm
module tb_iob_timer_alarm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  iob_timer_alarm_if bus();
  iob_timer_alarm dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask
  task automatic step(input logic [63:0] c);
    bus.cnt_i = c;
    @(posedge clk);
    #1;
    bus.deadline_wr = 1'b0;
    bus.arm         = 1'b0;
    bus.disarm      = 1'b0;
    bus.irq_ack     = 1'b0;
  endtask
  task automatic do_arm(input logic [63:0] dl, input logic [31:0] per, input logic per_mode);
    bus.deadline_wr = 1'b1;
    bus.deadline_i  = dl;
    bus.arm         = 1'b1;
    bus.period_i    = per;
    bus.periodic_i  = per_mode;
  endtask
  initial begin
    int first;
    int nf;
    int fires[3];
    logic [63:0] base;
    bus.cnt_i = '0; bus.deadline_wr = 0; bus.deadline_i = '0; bus.period_i = '0;
    bus.periodic_i = 0; bus.arm = 0; bus.disarm = 0; bus.irq_ack = 0;
    #1;
    chk("rst_irq", bus.irq, 0);
    chk("rst_armed", bus.armed, 0);
    chk("rst_deadline", bus.deadline_o, 0);
    chk("rst_miss", bus.miss_cnt, 0);
    #1 rst = 1'b1;
    // one-shot at 100
    bus.deadline_wr = 1; bus.deadline_i = 100;
    step(0);
    bus.arm = 1; bus.periodic_i = 0;
    step(0);
    first = -1;
    for (int c = 0; c <= 120; c++) begin
      step(c);
      if (bus.irq && first < 0) first = c;
    end
    chk("os_fire_cnt", first, 100);
    chk("os_irq_hold", bus.irq, 1);
    chk("os_armed", bus.armed, 1);
    chk("os_deadline", bus.deadline_o, 100);
    bus.irq_ack = 1;
    step(121);
    chk("os_ack", bus.irq, 0);
    for (int c = 122; c <= 130; c++) step(c);
    chk("os_no_refire", bus.irq, 0);
    chk("os_fired_armed", bus.armed, 1);
    chk("os_miss", bus.miss_cnt, 0);
    // periodic 50 + 20k with ack
    bus.disarm = 1;
    step(0);
    chk("dis_armed", bus.armed, 0);
    do_arm(50, 20, 1);
    step(0);
    nf = 0;
    for (int c = 0; c <= 100; c++) begin
      step(c);
      if (bus.irq) begin
        if (nf < 3) fires[nf] = c;
        nf++;
        bus.irq_ack = 1;
      end
    end
    chk("per_nfires", nf, 3);
    chk("per_fire0", fires[0], 50);
    chk("per_fire1", fires[1], 70);
    chk("per_fire2", fires[2], 90);
    chk("per_deadline", bus.deadline_o, 110);
    chk("per_miss", bus.miss_cnt, 0);
    // missed periods, never acked
    bus.disarm = 1;
    step(0);
    do_arm(0, 5, 1);
    step(0);
    for (int c = 0; c <= 29; c++) step(c);
    chk("miss_irq", bus.irq, 1);
    chk("miss_cnt5", bus.miss_cnt, 5);
    chk("miss_deadline", bus.deadline_o, 30);
    bus.disarm = 1;
    step(0);
    chk("miss_kept_disarm", bus.miss_cnt, 5);
    do_arm(0, 1, 1);
    step(0);
    chk("miss_clr_arm", bus.miss_cnt, 0);
    for (int c = 0; c <= 9; c++) step(c);
    chk("miss_cnt9", bus.miss_cnt, 9);
    for (int c = 10; c <= 299; c++) step(c);
    chk("miss_sat", bus.miss_cnt, 255);
    chk("miss_sat_deadline", bus.deadline_o, 300);
    // wrap-around and past deadline
    bus.disarm = 1;
    step(0);
    base = 64'hFFFF_FFFF_FFFF_FFFC;
    do_arm(4, 0, 0);
    step(base);
    first = -1;
    for (int i = 0; i <= 9; i++) begin
      step(base + 64'(i));
      if (bus.irq && first < 0) first = i;
    end
    chk("wrap_fire_idx", first, 8);
    bus.disarm = 1;
    step(0);
    do_arm(10, 0, 0);
    step(1000);
    chk("past_arm_edge", bus.irq, 0);
    step(1000);
    chk("past_fire", bus.irq, 1);
    // simultaneous events
    bus.disarm = 1;
    step(0);
    do_arm(0, 2, 1);
    step(0);
    step(0);
    chk("sim_fire", bus.irq, 1);
    step(1);
    bus.irq_ack = 1;
    step(2);
    chk("sim_ack_fire_irq", bus.irq, 1);
    chk("sim_ack_fire_miss", bus.miss_cnt, 0);
    bus.irq_ack = 1;
    step(3);
    chk("sim_ack", bus.irq, 0);
    bus.deadline_wr = 1; bus.deadline_i = 1000;
    step(4);
    chk("wr_no_old_fire", bus.irq, 0);
    chk("wr_deadline", bus.deadline_o, 1000);
    step(5);
    chk("wr_future", bus.irq, 0);
    bus.deadline_wr = 1; bus.deadline_i = 0;
    step(5);
    chk("wr_past_edge", bus.irq, 0);
    step(5);
    chk("wr_past_fire", bus.irq, 1);
    bus.disarm = 1; bus.arm = 1;
    step(6);
    chk("dis_arm_armed", bus.armed, 0);
    chk("dis_arm_irq", bus.irq, 0);
    // async reset mid-cycle
    do_arm(0, 0, 0);
    step(10);
    step(10);
    chk("pre_rst_irq", bus.irq, 1);
    chk("pre_rst_armed", bus.armed, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_irq", bus.irq, 0);
    chk("arst_armed", bus.armed, 0);
    chk("arst_deadline", bus.deadline_o, 0);
    chk("arst_miss", bus.miss_cnt, 0);
    #2 rst = 1'b1;
    for (int c = 20; c <= 25; c++) step(c);
    chk("post_rst_irq", bus.irq, 0);
    chk("post_rst_armed", bus.armed, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
